// File: rtl/i2s_stream_ctrl.sv
// Scheduler in front of the I2S master: divider-based clock enables, start/drain
// sequencing, frame-aligned two-source arbitration, mute and underrun substitution.
module i2s_stream_ctrl #(
   parameter int DIV_W  = 8,
   parameter int UCNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_enable,
   input  logic [DIV_W-1:0]  cfg_mclk_div,
   input  logic [DIV_W-1:0]  cfg_sclk_div,
   input  logic              cfg_src_sel,
   input  logic              cfg_mute,
   input  logic [47:0]       src0_data,
   input  logic              src0_valid,
   output logic              src0_ready,
   input  logic [47:0]       src1_data,
   input  logic              src1_valid,
   output logic              src1_ready,
   output logic              mclk_en,
   output logic              sclk_en,
   output logic              i2s_rst,
   output logic [47:0]       i2s_data,
   output logic              i2s_valid,
   input  logic              i2s_ready,
   output logic              running,
   output logic              active_src,
   output logic [UCNT_W-1:0] underrun_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DRAIN} state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   mclk_div_q, mclk_div_d;
   logic [DIV_W-1:0]   sclk_div_q, sclk_div_d;
   logic [DIV_W-1:0]   mclk_cnt_q, mclk_cnt_d;
   logic [DIV_W-1:0]   sclk_cnt_q, sclk_cnt_d;
   logic [47:0]        out_q, out_d;
   logic               active_src_q, active_src_d;
   logic [UCNT_W-1:0]  ucnt_q, ucnt_d;

   logic [47:0] src_data [2];
   logic [1:0]  src_valid;
   logic [1:0]  src_ready;
   logic        sel_valid;
   logic [47:0] sel_data;
   logic        clk_on;
   logic        boundary;
   logic        pop;

   assign src_data[0] = src0_data;
   assign src_data[1] = src1_data;
   assign src_valid   = {src1_valid, src0_valid};
   assign sel_valid   = src_valid[cfg_src_sel];
   assign sel_data    = src_data[cfg_src_sel];

   assign clk_on   = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign boundary = (state_q == S_RUN) && i2s_ready;
   // Only the currently requested source can be popped, so both readies are never high together.
   assign pop      = ((state_q == S_START) || boundary) && sel_valid;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         assign src_ready[gi] = pop && (cfg_src_sel == 1'(gi));
      end
   endgenerate

   assign src0_ready   = src_ready[0];
   assign src1_ready   = src_ready[1];
   assign mclk_en      = clk_on && (mclk_cnt_q == mclk_div_q);
   assign sclk_en      = clk_on && (sclk_cnt_q == sclk_div_q);
   assign i2s_rst      = (state_q == S_IDLE);
   assign i2s_valid    = clk_on;
   assign i2s_data     = out_q;
   assign running      = (state_q != S_IDLE);
   assign active_src   = active_src_q;
   assign underrun_cnt = ucnt_q;

   always_comb begin
      state_d      = state_q;
      mclk_div_d   = mclk_div_q;
      sclk_div_d   = sclk_div_q;
      mclk_cnt_d   = '0;
      sclk_cnt_d   = '0;
      out_d        = out_q;
      active_src_d = active_src_q;
      ucnt_d       = ucnt_q;

      // Counters sit at zero outside RUN/DRAIN so the first pulse lands div+1 cycles into RUN.
      if (clk_on) begin
         mclk_cnt_d = (mclk_cnt_q == mclk_div_q) ? '0 : mclk_cnt_q + 1'b1;
         sclk_cnt_d = (sclk_cnt_q == sclk_div_q) ? '0 : sclk_cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            mclk_div_d = cfg_mclk_div;
            sclk_div_d = cfg_sclk_div;
            if (cfg_enable) begin
               state_d = S_START;
               ucnt_d  = '0;
            end
         end
         S_START: begin
            state_d      = S_RUN;
            active_src_d = cfg_src_sel;
            out_d        = (sel_valid && !cfg_mute) ? sel_data : '0;
         end
         S_RUN: begin
            if (i2s_ready) begin
               active_src_d = cfg_src_sel;
               if (sel_valid) begin
                  out_d = cfg_mute ? '0 : sel_data;
               end else begin
                  out_d = '0;
                  if (ucnt_q != '1) ucnt_d = ucnt_q + 1'b1;
               end
            end
            if (!cfg_enable) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (i2s_ready) begin
               out_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         mclk_div_q   <= '0;
         sclk_div_q   <= '0;
         mclk_cnt_q   <= '0;
         sclk_cnt_q   <= '0;
         out_q        <= '0;
         active_src_q <= 1'b0;
         ucnt_q       <= '0;
      end else begin
         state_q      <= state_d;
         mclk_div_q   <= mclk_div_d;
         sclk_div_q   <= sclk_div_d;
         mclk_cnt_q   <= mclk_cnt_d;
         sclk_cnt_q   <= sclk_cnt_d;
         out_q        <= out_d;
         active_src_q <= active_src_d;
         ucnt_q       <= ucnt_d;
      end
   end

endmodule

// File: tb/tb_i2s_stream_ctrl.sv
// Directed bench for i2s_stream_ctrl: a per-cycle vector table for the main flow,
// then hand sequences for divider periods, drain, underrun, async reset and saturation.
module tb_i2s_stream_ctrl;

   logic        clk;
   logic        rst_n;
   logic        cfg_enable;
   logic [7:0]  cfg_mclk_div;
   logic [7:0]  cfg_sclk_div;
   logic        cfg_src_sel;
   logic        cfg_mute;
   logic [47:0] src0_data;
   logic        src0_valid;
   logic        src0_ready;
   logic [47:0] src1_data;
   logic        src1_valid;
   logic        src1_ready;
   logic        mclk_en;
   logic        sclk_en;
   logic        i2s_rst;
   logic [47:0] i2s_data;
   logic        i2s_valid;
   logic        i2s_ready;
   logic        running;
   logic        active_src;
   logic [15:0] underrun_cnt;

   i2s_stream_ctrl #(.DIV_W(8), .UCNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable),
      .cfg_mclk_div(cfg_mclk_div), .cfg_sclk_div(cfg_sclk_div),
      .cfg_src_sel(cfg_src_sel), .cfg_mute(cfg_mute),
      .src0_data(src0_data), .src0_valid(src0_valid), .src0_ready(src0_ready),
      .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(src1_ready),
      .mclk_en(mclk_en), .sclk_en(sclk_en), .i2s_rst(i2s_rst),
      .i2s_data(i2s_data), .i2s_valid(i2s_valid), .i2s_ready(i2s_ready),
      .running(running), .active_src(active_src), .underrun_cnt(underrun_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ctl bits: {i2s_rst, running, i2s_valid, mclk_en, sclk_en, src0_ready, src1_ready, active_src}
   logic [71:0] obs;
   assign obs = {i2s_rst, running, i2s_valid, mclk_en, sclk_en, src0_ready, src1_ready,
                 active_src, i2s_data, underrun_cnt};

   typedef struct packed {
      logic        en;
      logic        sel;
      logic        mute;
      logic        v0;
      logic [47:0] d0;
      logic        v1;
      logic [47:0] d1;
      logic        rdy;
      logic [7:0]  ctl;
      logic [47:0] edata;
      logic [15:0] eucnt;
   } vec_t;

   localparam logic [47:0] Z  = 48'h0;
   localparam logic [47:0] D1 = 48'h111111_222222;
   localparam logic [47:0] D2 = 48'h333333_444444;
   localparam logic [47:0] D3 = 48'h555555_666666;
   localparam logic [47:0] E1 = 48'h0A0B0C_0D0E0F;
   localparam logic [47:0] EM = 48'hABCDEF_123456;

   vec_t tv [16];
   int   n_vec;
   int   n_miss;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [47:0] pat;
   logic [47:0] exp_data;
   logic [15:0] exp_ucnt;
   logic        rdy;
   logic        v;

   initial begin
      n_vec = 0;
      n_miss = 0;
      //            en    sel   mute  v0    d0  v1    d1  rdy   ctl           edata eucnt
      tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, Z,  1'b0, Z,  1'b0, 8'b1000_0000, Z,  16'd0};
      tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, D1, 1'b0, Z,  1'b0, 8'b1000_0000, Z,  16'd0};
      tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, D1, 1'b0, Z,  1'b0, 8'b0100_0100, Z,  16'd0};
      tv[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, D2, 1'b0, Z,  1'b0, 8'b0110_0000, D1, 16'd0};
      tv[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, D2, 1'b0, Z,  1'b0, 8'b0111_0000, D1, 16'd0};
      tv[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, D2, 1'b0, Z,  1'b1, 8'b0110_0100, D1, 16'd0};
      tv[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, Z,  1'b0, Z,  1'b0, 8'b0111_1000, D2, 16'd0};
      tv[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, Z,  1'b0, Z,  1'b1, 8'b0110_0000, D2, 16'd0};
      tv[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, Z,  1'b0, Z,  1'b0, 8'b0111_0000, Z,  16'd1};
      tv[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, Z,  1'b1, E1, 1'b0, 8'b0110_0000, Z,  16'd1};
      tv[10] = '{1'b1, 1'b1, 1'b0, 1'b1, D3, 1'b1, E1, 1'b1, 8'b0111_1010, Z,  16'd1};
      tv[11] = '{1'b1, 1'b1, 1'b1, 1'b1, D3, 1'b1, EM, 1'b1, 8'b0110_0011, E1, 16'd1};
      tv[12] = '{1'b0, 1'b1, 1'b1, 1'b1, D3, 1'b1, EM, 1'b0, 8'b0111_0001, Z,  16'd1};
      tv[13] = '{1'b0, 1'b1, 1'b0, 1'b1, D3, 1'b1, EM, 1'b0, 8'b0110_0001, Z,  16'd1};
      tv[14] = '{1'b1, 1'b1, 1'b0, 1'b1, D3, 1'b1, EM, 1'b1, 8'b0111_1001, Z,  16'd1};
      tv[15] = '{1'b0, 1'b1, 1'b0, 1'b1, D3, 1'b1, EM, 1'b0, 8'b1000_0001, Z,  16'd1};

      rst_n = 1'b0; cfg_enable = 1'b0; cfg_mclk_div = 8'd1; cfg_sclk_div = 8'd3;
      cfg_src_sel = 1'b0; cfg_mute = 1'b0; src0_data = Z; src0_valid = 1'b0;
      src1_data = Z; src1_valid = 1'b0; i2s_ready = 1'b0;
      #2;
      chk("reset_state", {56'd0, obs}, {56'd0, 8'b1000_0000, Z, 16'd0});
      step();
      rst_n = 1'b1;

      // Main flow table: one row per clock cycle.
      for (int i = 0; i < 16; i++) begin
         cfg_enable = tv[i].en; cfg_src_sel = tv[i].sel; cfg_mute = tv[i].mute;
         src0_valid = tv[i].v0; src0_data = tv[i].d0;
         src1_valid = tv[i].v1; src1_data = tv[i].d1; i2s_ready = tv[i].rdy;
         @(negedge clk);
         chk($sformatf("table_row_%0d", i), {56'd0, obs}, {56'd0, tv[i].ctl, tv[i].edata, tv[i].eucnt});
         $display("vec %0d en=%0d sel=%0d rdy=%0d data=%h ucnt=%0d", i, tv[i].en, tv[i].sel,
                  tv[i].rdy, i2s_data, underrun_cnt);
         step();
      end

      // Divider periods, data ordering, shadowed divider, drain.
      cfg_mclk_div = 8'd1; cfg_sclk_div = 8'd7; cfg_mute = 1'b0; cfg_src_sel = 1'b0;
      src1_valid = 1'b0; src0_valid = 1'b1; pat = 48'd1; src0_data = pat;
      cfg_enable = 1'b1; i2s_ready = 1'b0;
      step();
      @(negedge clk);
      chk("start_pop_src0", {126'd0, src0_ready, src1_ready}, {126'd0, 2'b10});
      chk("ucnt_cleared_on_start", {112'd0, underrun_cnt}, 128'd0);
      @(posedge clk);
      exp_data = pat; pat = pat + 1'b1;
      #1; src0_data = pat;
      for (int k = 0; k < 40; k++) begin
         rdy = (k % 10 == 9);
         i2s_ready = rdy;
         if (k == 20) cfg_sclk_div = 8'd2;
         if (k == 34) cfg_enable = 1'b0;
         @(negedge clk);
         chk($sformatf("divA_k%0d", k), {126'd0, mclk_en, sclk_en},
             {126'd0, (k % 2 == 1), (k % 8 == 7)});
         chk($sformatf("popA_k%0d", k), {126'd0, src0_ready, src1_ready},
             {126'd0, rdy && (k <= 34), 1'b0});
         chk($sformatf("dataA_k%0d", k), {80'd0, i2s_data}, {80'd0, exp_data});
         chk($sformatf("linkA_k%0d", k), {125'd0, i2s_rst, running, i2s_valid}, {125'd0, 3'b011});
         @(posedge clk);
         if (rdy && k <= 34) begin
            exp_data = pat; pat = pat + 1'b1;
         end
         #1; src0_data = pat;
      end
      i2s_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("idle_after_drain_%0d", k),
             {75'd0, i2s_rst, running, i2s_valid, mclk_en, sclk_en, i2s_data},
             {75'd0, 5'b10000, Z});
         step();
      end

      // Restart: new dividers take effect, START without data, three underruns.
      cfg_mclk_div = 8'd0; src0_valid = 1'b0; cfg_enable = 1'b1;
      step();
      @(negedge clk);
      chk("start_no_pop", {125'd0, running, src0_ready, src1_ready}, {125'd0, 3'b100});
      step();
      exp_data = Z; exp_ucnt = 16'd0;
      for (int k = 0; k < 30; k++) begin
         rdy = (k % 5 == 4);
         v = (k >= 15);
         i2s_ready = rdy; src0_valid = v; src0_data = pat;
         @(negedge clk);
         chk($sformatf("divB_k%0d", k), {126'd0, mclk_en, sclk_en}, {126'd0, 1'b1, (k % 3 == 2)});
         chk($sformatf("popB_k%0d", k), {127'd0, src0_ready}, {127'd0, rdy && v});
         chk($sformatf("dataB_k%0d", k), {80'd0, i2s_data}, {80'd0, exp_data});
         chk($sformatf("ucntB_k%0d", k), {112'd0, underrun_cnt}, {112'd0, exp_ucnt});
         @(posedge clk);
         if (rdy) begin
            if (v) begin
               exp_data = pat; pat = pat + 1'b1;
            end else begin
               exp_data = Z; exp_ucnt = exp_ucnt + 1'b1;
            end
         end
         #1;
      end
      chk("ucnt_three", {112'd0, underrun_cnt}, {112'd0, 16'd3});

      // Asynchronous reset in the middle of a frame.
      i2s_ready = 1'b1; src0_valid = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_reset", {56'd0, obs}, {56'd0, 8'b1000_0000, Z, 16'd0});
      step();
      rst_n = 1'b1;

      // Underrun counter saturation: a boundary every cycle with no data.
      src0_valid = 1'b0; i2s_ready = 1'b1; cfg_enable = 1'b1;
      step();
      step();
      for (int n = 0; n < 65534; n++) step();
      @(negedge clk);
      chk("ucnt_fffe", {112'd0, underrun_cnt}, {112'd0, 16'hFFFE});
      step();
      @(negedge clk);
      chk("ucnt_ffff", {112'd0, underrun_cnt}, {112'd0, 16'hFFFF});
      step(); step(); step();
      @(negedge clk);
      chk("ucnt_saturated", {112'd0, underrun_cnt}, {112'd0, 16'hFFFF});

      cfg_enable = 1'b0; i2s_ready = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
